// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsk_pkg
// Purpose  : Shared types and default constants for the FSK receive controller
// Revision : 1.0
// ============================================================================
package fsk_pkg;

  // Receive framing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } fsk_rx_state_t;

  localparam int FSK_SAMPLES_PER_BIT = 64;
  localparam int FSK_PEAK_THRESH     = 6;
  localparam int FSK_DATA_BITS       = 8;
  localparam int FSK_CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/fsk_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fsk_rx_ctrl_if
// Purpose  : Byte valid/ready handshake between the FSK receiver and consumer
// Revision : 1.0
// ============================================================================
interface fsk_rx_ctrl_if
  import fsk_pkg::*;
#(
  parameter int DATA_BITS = FSK_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  // Receiver side drives the byte, consumer side drives ready
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface
`default_nettype wire

// File: rtl/fsk_bit_window.sv
`default_nettype none
// ============================================================================
// Module   : fsk_bit_window
// Purpose  : Fixed-length bit window; counts peak pulses (saturating) and
//            issues a mark/space decision in the final cycle of each window
// Revision : 1.0
// ============================================================================
module fsk_bit_window
  import fsk_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = FSK_SAMPLES_PER_BIT,
  parameter int CNT_W           = FSK_CNT_W,
  parameter int PEAK_THRESH     = FSK_PEAK_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic peak_pulse,
  output logic bit_valid,
  output logic bit_val
);

  localparam int               WIN_W    = $clog2(SAMPLES_PER_BIT);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PK_MAX   = '1;
  localparam logic [CNT_W:0]   THRESH   = (CNT_W + 1)'(PEAK_THRESH);

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] pk_cnt;
  logic [CNT_W-1:0] pk_inc;
  logic             win_end;

  // Count including this cycle's pulse so a pulse in the last cycle still
  // contributes to the decision taken in that same cycle
  always_comb begin
    pk_inc    = (peak_pulse && (pk_cnt != PK_MAX)) ? pk_cnt + CNT_W'(1) : pk_cnt;
    win_end   = run && (win_cnt == WIN_LAST);
    bit_valid = win_end;
    bit_val   = ({1'b0, pk_inc} >= THRESH);
  end

  // Window and peak counters; both restart at zero after the final cycle
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      win_cnt <= '0;
      pk_cnt  <= '0;
    end else if (win_end) begin
      win_cnt <= '0;
      pk_cnt  <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      pk_cnt  <= pk_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsk_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fsk_rx_ctrl
// Purpose  : FSK receive controller; frames window decisions into
//            start/data/stop characters and hands bytes downstream
// Revision : 1.0
// ============================================================================
module fsk_rx_ctrl
  import fsk_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = FSK_SAMPLES_PER_BIT,
  parameter int CNT_W           = FSK_CNT_W,
  parameter int PEAK_THRESH     = FSK_PEAK_THRESH,
  parameter int DATA_BITS       = FSK_DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              peak_pulse,
  fsk_rx_ctrl_if.master     rx,
  output logic              bit_out,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  fsk_rx_state_t        state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 bit_out_q, bit_out_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 run, bit_valid, bit_val;

  // Windows only run while enabled and out of IDLE so they align to HUNT entry
  assign run = en && (state_q != IDLE);

  fsk_bit_window #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .CNT_W           (CNT_W),
    .PEAK_THRESH     (PEAK_THRESH)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .peak_pulse (peak_pulse),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val)
  );

  // Next-state, shift register, handshake and pulse generation
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q && !rx.rx_ready;
    bit_out_d   = bit_valid ? bit_val : bit_out_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      bit_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (bit_valid && !bit_val) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (bit_valid) begin
            shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_LAST) begin
              state_d   = STOP;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (bit_valid) begin
            state_d = HUNT;
            if (!bit_val) begin
              frame_err_d = 1'b1;
            end else if (!valid_q || rx.rx_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      bit_out_q   <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      bit_out_q   <= bit_out_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;
  assign bit_out     = bit_out_q;
  assign busy        = (state_q == DATA) || (state_q == STOP);
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsk_rx_ctrl
// Purpose  : Scoreboard bench for fsk_rx_ctrl (16 samples/bit, threshold 4,
//            3-bit saturating peak counter)
// Revision : 1.0
// ============================================================================
module tb_fsk_rx_ctrl;

  localparam int SPB = 16;
  localparam int CMAX = 7;
  localparam int THR = 4;

  typedef struct { int kind; int data; int due; } ev_t;   // kind 0 byte, 1 frame_err, 2 overrun
  typedef struct { bit val; int due; } bx_t;

  logic clk = 1'b0;
  logic rst, en, peak_pulse;
  logic bit_out, busy, frame_err, overrun;

  fsk_rx_ctrl_if #(.DATA_BITS(8)) rx_if ();

  fsk_rx_ctrl #(
    .SAMPLES_PER_BIT (SPB),
    .CNT_W           (3),
    .PEAK_THRESH     (THR),
    .DATA_BITS       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .peak_pulse (peak_pulse),
    .rx         (rx_if),
    .bit_out    (bit_out),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  nchecks = 0;
  int  nerrors = 0;
  ev_t evq[$];
  bx_t bitq[$];

  // Reference model state: framing over the stream of window decisions
  bit  in_frame = 0;
  bit  fbits[$];
  bit  model_pending = 0;
  bit  rand_mode = 0;
  int  ready_mode = 2;   // 0 random, 1 held low, 2 held high

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    nchecks++;
    if (!ok) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model of one finished window with n peaks
  task automatic model_window(input int n);
    bit  dec;
    int  b;
    ev_t e;
    dec = ((n > CMAX) ? CMAX : n) >= THR;
    bitq.push_back('{val: dec, due: cyc + 1});
    if (!in_frame) begin
      if (!dec) begin
        in_frame = 1;
        fbits.delete();
      end
    end else begin
      fbits.push_back(dec);
      if (fbits.size() == 9) begin
        in_frame = 0;
        b = 0;
        for (int i = 0; i < 8; i++) b += int'(fbits[i]) << i;
        e.due  = cyc + 1;
        e.data = b;
        if (!fbits[8]) e.kind = 1;
        else if (ready_mode == 1 && model_pending) e.kind = 2;
        else begin
          e.kind = 0;
          model_pending = 1;
        end
        evq.push_back(e);
      end
    end
  endtask

  // Drive one 16-cycle window with n pulses at random distinct positions
  task automatic drive_window(input int n);
    bit [SPB-1:0] m;
    int placed, p;
    m = '0;
    placed = 0;
    while (placed < n) begin
      p = $urandom_range(SPB - 1, 0);
      if (!m[p]) begin
        m[p] = 1'b1;
        placed++;
      end
    end
    for (int j = 0; j < SPB; j++) begin
      peak_pulse = m[j];
      if (j == SPB - 1) model_window(n);
      @(posedge clk); #1;
    end
    peak_pulse = 1'b0;
  endtask

  function automatic int cnt_for(input bit b);
    if (rand_mode) return b ? int'($urandom_range(16, 4)) : int'($urandom_range(3, 0));
    return b ? 6 : 2;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop);
    drive_window(cnt_for(1'b0));
    for (int i = 0; i < 8; i++) drive_window(cnt_for(d[i]));
    drive_window(cnt_for(stop));
  endtask

  task automatic start_rx();
    en = 1'b1;
    @(posedge clk); #1;
    in_frame = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(rx_if.rx_valid == 1'b0, {tag, "_rx_valid"}, rx_if.rx_valid, 0);
    check(rx_if.rx_data == 8'h00, {tag, "_rx_data"}, rx_if.rx_data, 0);
    check(bit_out == 1'b1, {tag, "_bit_out"}, bit_out, 1);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(frame_err == 1'b0, {tag, "_frame_err"}, frame_err, 0);
    check(overrun == 1'b0, {tag, "_overrun"}, overrun, 0);
  endtask

  task automatic observe(input int kind, input int data);
    ev_t e;
    check(evq.size() != 0, "event_expected", kind, -1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      check(e.kind == kind, "event_kind", kind, e.kind);
      check(e.due == cyc, "event_cycle", cyc, e.due);
      if (kind == 0) check(data == e.data, "rx_data_byte", data, e.data);
    end
  endtask

  // Consumer: rx_ready policy
  initial begin
    rx_if.rx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rx_if.rx_ready = ($urandom_range(9, 0) < 7);
        1:       rx_if.rx_ready = 1'b0;
        default: rx_if.rx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents something
  initial begin
    bit pv, pr;
    logic [7:0] held;
    pv = 0; pr = 0; held = '0;
    forever begin
      @(negedge clk);
      if (bitq.size() != 0 && bitq[0].due <= cyc) begin
        bx_t bx;
        bx = bitq.pop_front();
        check(bx.due == cyc, "bit_cycle", cyc, bx.due);
        check(bit_out == bx.val, "bit_out", bit_out, bx.val);
      end
      if (rx_if.rx_valid && (!pv || pr)) begin
        observe(0, int'(rx_if.rx_data));
        held = rx_if.rx_data;
      end else if (rx_if.rx_valid && pv) begin
        check(rx_if.rx_data == held, "rx_data_stable", rx_if.rx_data, held);
      end
      if (frame_err) observe(1, 0);
      if (overrun) observe(2, 0);
      if (evq.size() != 0 && evq[0].due < cyc) begin
        check(1'b0 != 1'b0 || evq[0].due >= cyc, "event_missing", cyc, evq[0].due);
        void'(evq.pop_front());
      end
      pv = rx_if.rx_valid;
      pr = rx_if.rx_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; peak_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle line: five mark windows, nothing framed
    start_rx();
    repeat (5) drive_window(6);
    check(busy == 1'b0, "idle_busy", busy, 0);
    check(rx_if.rx_valid == 1'b0, "idle_rx_valid", rx_if.rx_valid, 0);

    // 0xA5 with the consumer always ready
    send_frame(8'hA5, 1'b1);
    check(rx_if.rx_valid == 1'b1, "a5_valid", rx_if.rx_valid, 1);
    check(rx_if.rx_data == 8'hA5, "a5_data", rx_if.rx_data, 8'hA5);
    drive_window(6);
    check(rx_if.rx_valid == 1'b0, "a5_accepted", rx_if.rx_valid, 0);

    // Framing error then a good frame
    send_frame(8'h5A, 1'b0);
    check(rx_if.rx_valid == 1'b0, "ferr_no_valid", rx_if.rx_valid, 0);
    send_frame(8'h3C, 1'b1);

    // Threshold and saturation boundaries inside one frame
    begin
      int c [10] = '{2, 4, 3, 16, 3, 4, 0, 7, 5, 6};
      for (int i = 0; i < 10; i++) drive_window(c[i]);
    end

    // Randomized traffic with a random consumer
    rand_mode = 1; ready_mode = 0;
    for (int k = 0; k < 25; k++) begin
      int gap;
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) drive_window(cnt_for(1'b1));
      send_frame(8'($urandom_range(255, 0)), $urandom_range(99, 0) < 85);
    end
    drive_window(cnt_for(1'b1));
    drive_window(cnt_for(1'b1));

    // Overrun: consumer stalled across two bytes
    rand_mode = 0; ready_mode = 1; model_pending = 0;
    drive_window(6);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check(rx_if.rx_valid == 1'b1, "ovr_valid", rx_if.rx_valid, 1);
    check(rx_if.rx_data == 8'h11, "ovr_data", rx_if.rx_data, 8'h11);
    ready_mode = 2;
    drive_window(6);
    check(rx_if.rx_valid == 1'b0, "ovr_accepted", rx_if.rx_valid, 0);

    // en dropped mid-DATA
    drive_window(2);
    repeat (3) drive_window(6);
    check(busy == 1'b1, "en_busy_before", busy, 1);
    en = 1'b0;
    @(posedge clk); #1;
    check(busy == 1'b0, "en_busy_after", busy, 0);
    in_frame = 0;
    start_rx();

    // rst mid-DATA
    drive_window(2);
    drive_window(2);
    drive_window(2);
    check(busy == 1'b1, "rst_busy_before", busy, 1);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    in_frame = 0;
    @(posedge clk); #1;
    start_rx();
    send_frame(8'h96, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check(evq.size() == 0, "events_drained", evq.size(), 0);
    check(bitq.size() == 0, "bits_drained", bitq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsk_rx_ctrl.md
# fsk_rx_ctrl

Receive-side controller for the FSK peak-detection demodulator. It takes the detector's one-cycle peak pulses and counts them over fixed bit windows. Each window becomes a mark (1) or space (0) decision. The controller frames the decided bits into start/8-data/stop characters and presents each byte on a valid/ready handshake to the downstream consumer. It sits between the peak detector and the byte-level link logic.

## Interface
Parameters:
- SAMPLES_PER_BIT, 64: clk cycles per bit window, ≥ 4.
- CNT_W, 8: width of the peak counter (saturating).
- PEAK_THRESH, 6: peaks per window at or above which the bit is mark (1).
- DATA_BITS, 8: data bits per character, LSB first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  receiver enable.
- peak_pulse  in  1  one-cycle pulse from the peak detector per detected local maximum.
- rx_data  out  DATA_BITS  received byte; stable while rx_valid.
- rx_valid  out  1  byte available.
- rx_ready  in  1  consumer accepts the byte when high with rx_valid.
- bit_out  out  1  last window decision (demodulated line level).
- busy  out  1  high in DATA or STOP.
- frame_err  out  1  one-cycle pulse when a stop window decodes as space.
- overrun  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- Window engine: win_cnt runs 0..SAMPLES_PER_BIT-1 and wraps. pk_cnt counts peak_pulse and saturates at 2^CNT_W-1. A peak_pulse in the final cycle of a window is counted in that window. At the end of the window, bit = (pk_cnt ≥ PEAK_THRESH). pk_cnt then restarts at 0, or at 1 if a pulse coincides with the first cycle of the next window.
- FSM states: IDLE, HUNT, DATA, STOP.
  - IDLE: counters held at 0. en=1 moves to HUNT on the next cycle.
  - HUNT: windows run freely. A space decision is the start bit: go to DATA with bit index 0. A mark decision stays in HUNT.
  - DATA: each window decision shifts into the data shift register, LSB first. After DATA_BITS windows, go to STOP.
  - STOP: the window decides the stop bit.
    - Mark: the byte is complete.
    - Space: pulse frame_err for one cycle, discard the byte, return to HUNT.
- Byte complete with no pending byte, or with the pending byte being accepted in the same cycle: load rx_data and assert rx_valid.
- Byte complete while rx_valid=1 and rx_ready=0: pulse overrun for one cycle. The new byte is dropped and the old byte is retained.
- After STOP, the FSM returns to HUNT in all cases.
- en=0 in any state: go to IDLE next cycle and clear the window, peak and bit counters. A pending rx_valid/rx_data is retained and can still be handshaken.

## Timing
- Reset values:
  - rx_data = 0, rx_valid = 0, bit_out = 1 (mark).
  - busy = 0, frame_err = 0, overrun = 0.
  - State = IDLE; counters = 0.
- Decision latency: bit_out updates on the cycle after the final cycle of a window.
- Frame latency: rx_valid rises 1 cycle after the last cycle of the stop window, which is 10 windows after the start window begins.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, and falls the next cycle.
  - rx_ready while rx_valid=0 has no effect.
  - rx_data does not change while rx_valid=1.
- frame_err and overrun are asserted for exactly one cycle, aligned with the cycle rx_valid would have risen.
- busy is high from the cycle after the start decision through the cycle the STOP decision registers.
- rst mid-frame: all state returns to reset values on the next edge, with no pulses emitted.

## Structure
- Package fsk_pkg:
  - state enum fsk_rx_state_t (IDLE, HUNT, DATA, STOP).
  - default constants FSK_SAMPLES_PER_BIT, FSK_PEAK_THRESH, FSK_DATA_BITS.
- Sub-module fsk_bit_window:
  - Contains the window counter, the saturating peak counter and the threshold compare.
  - Outputs bit_valid (1-cycle pulse) and bit_val.
- fsk_rx_ctrl holds the FSM, shift register, bit index and output/handshake registers.

## Test plan
All scenarios use SAMPLES_PER_BIT=16, PEAK_THRESH=4. Mark = 6 peaks/window, space = 2 peaks/window.
- Idle line: en=1, 5 mark windows → bit_out=1 throughout, busy=0, no rx_valid.
- Byte 0xA5: start(space), bits 1,0,1,0,0,1,0,1, stop(mark) → rx_valid 1 cycle after the stop window ends, rx_data=0xA5; rx_ready=1 drops rx_valid the next cycle.
- Framing error: frame with stop=space → frame_err single pulse, rx_valid stays 0, FSM back to HUNT; a following 0x3C frame is received correctly.
- Overrun: receive 0x11 with rx_ready=0, then 0x22 → overrun pulse, rx_data remains 0x11; after accept, rx_valid=0.
- Threshold/saturation: a window with exactly 4 peaks → mark, 3 → space; a pulse on every cycle of a window with CNT_W=3 → counter saturates at 7, decision mark.
- Disruption: en=0 mid-DATA → IDLE next cycle with busy=0. rst mid-DATA → all outputs at reset values, no frame_err.
